// File: rtl/reg_buffer_pkg.sv
// Shared definitions for the register-based buffer FIFO.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   clog2()               : ceiling log2, used to size pointers and the count
//   next_ptr()            : wrap-around pointer advance, valid for any depth
package reg_buffer_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_DEPTH = 4;

  // Smallest r with 2**r >= value. Bounded loop keeps it synthesizable.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Wrap at depth-1 explicitly so non-power-of-two depths work.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word of the buffer: WIDTH-bit register with load enable.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, clears the word to 0
//   load_i  capture d_i on this edge
//   d_i     write data
//   q_o     stored word
module reg_word #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_buffer_fifo.sv
// Register-based FIFO buffer with valid/ready on both sides and first-word
// fall-through output. Storage is DEPTH reg_word instances; pointers and the
// occupancy count live here.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   flush              synchronous clear of pointers/count (storage retained)
//   in_valid/in_ready  write handshake, in_data write word
//   out_valid/out_ready read handshake, out_data oldest word
//   count, full, empty occupancy status from registered state
module reg_buffer_fifo
  import reg_buffer_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign out_data  = mem[rd_ptr_q];

  // in_ready is !full, so a push never lands on a full buffer even if a pop
  // happens in the same cycle.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(next_ptr(int'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(next_ptr(int'(rd_ptr_q), DEPTH));
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flushed push must not touch storage either.
  for (genvar i = 0; i < DEPTH; i++) begin : g_store
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (push && !flush && (wr_ptr_q == PTR_W'(i))),
      .d_i    (in_data),
      .q_o    (mem[i])
    );
  end

endmodule

// File: tb/tb_reg_buffer_fifo.sv
module tb_reg_buffer_fifo;

  localparam int W = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic         rst_n, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, full, empty;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  // DEPTH=3 instance
  logic         rst_n3, flush3, in_valid3, out_ready3;
  logic [W-1:0] in_data3;
  logic         in_ready3, out_valid3, full3, empty3;
  logic [W-1:0] out_data3;
  logic [1:0]   count3;

  reg_buffer_fifo #(.WIDTH(W), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  reg_buffer_fifo #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .flush(flush3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .count(count3), .full(full3), .empty(empty3)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q4[$];
  logic [W-1:0] exp_q3[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor DEPTH=4: pops at negedge when a transfer will happen on the next edge.
  logic         stall4 = 1'b0;
  logic [W-1:0] held4 = '0;
  always @(negedge clk) begin
    if (stall4) begin
      check("hold_valid4", W'(out_valid), W'(1));
      check("hold_data4", out_data, held4);
    end
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out4: got %0h expected no output", out_data);
      end else begin
        check("out_data4", out_data, exp_q4.pop_front());
      end
    end
    stall4 = rst_n && !flush && out_valid && !out_ready;
    held4  = out_data;
  end

  always @(negedge clk) begin
    if (rst_n3 && !flush3 && out_valid3 && out_ready3) begin
      if (exp_q3.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out3: got %0h expected no output", out_data3);
      end else begin
        check("out_data3", out_data3, exp_q3.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; flush = 0; in_valid = 1; in_data = W'(32'hDEAD); out_ready = 0;
    rst_n3 = 0; flush3 = 0; in_valid3 = 0; in_data3 = '0; out_ready3 = 0;
    step(); step();
    check("rst_count", W'(count), W'(0));
    check("rst_empty", W'(empty), W'(1));
    check("rst_full", W'(full), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    in_valid = 0; rst_n = 1; rst_n3 = 1;
    step();

    // Fill to full, then a rejected fifth word
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = W'(8'hA0 + k); exp_q4.push_back(W'(8'hA0 + k));
      step();
    end
    check("fill_count", W'(count), W'(4));
    check("fill_full", W'(full), W'(1));
    check("fill_in_ready", W'(in_ready), W'(0));
    in_data = W'(8'hA4);
    step();
    check("overflow_count", W'(count), W'(4));
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) step();
    check("drain_empty", W'(empty), W'(1));
    check("drain_count", W'(count), W'(0));
    out_ready = 0;

    // Simultaneous push/pop at count=2 across wrap
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_data = W'(8'hB0 + k); exp_q4.push_back(W'(8'hB0 + k));
      step();
    end
    out_ready = 1;
    for (int k = 2; k < 12; k++) begin
      in_data = W'(8'hB0 + k); exp_q4.push_back(W'(8'hB0 + k));
      step();
      check("pushpop_count", W'(count), W'(2));
    end
    in_valid = 0;
    step(); step();
    check("pushpop_empty", W'(empty), W'(1));
    out_ready = 0;

    // Backpressure with one word
    in_valid = 1; in_data = W'(8'hC0); exp_q4.push_back(W'(8'hC0));
    step();
    in_valid = 0; in_data = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_count", W'(count), W'(1));
      check("bp_data", out_data, W'(8'hC0));
    end
    out_ready = 1; step(); out_ready = 0;
    check("bp_empty", W'(empty), W'(1));

    // Flush mid-burst
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = W'(8'hD0 + k); exp_q4.push_back(W'(8'hD0 + k));
      step();
    end
    check("pre_flush_count", W'(count), W'(3));
    flush = 1; in_data = W'(8'hFF);
    step();
    exp_q4.delete();
    flush = 0; in_valid = 0;
    check("flush_count", W'(count), W'(0));
    check("flush_empty", W'(empty), W'(1));
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_out_valid", W'(out_valid), W'(0));
    out_ready = 1;
    step(); step(); step();
    in_valid = 1; in_data = W'(8'hE0); exp_q4.push_back(W'(8'hE0));
    step();
    in_valid = 0;
    step();
    check("post_flush_empty", W'(empty), W'(1));
    out_ready = 0;

    // DEPTH=3: push 7, pop each one cycle later
    in_valid3 = 1; in_data3 = W'(8'hF0); exp_q3.push_back(W'(8'hF0));
    step();
    out_ready3 = 1;
    for (int k = 1; k < 7; k++) begin
      in_data3 = W'(8'hF0 + k); exp_q3.push_back(W'(8'hF0 + k));
      step();
      check("d3_count", W'(count3), W'(1));
    end
    in_valid3 = 0;
    step();
    check("d3_empty", W'(empty3), W'(1));
    out_ready3 = 0;
    step();

    check("q4_drained", W'(exp_q4.size()), W'(0));
    check("q3_drained", W'(exp_q3.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
